rtc_bus_responder: RTL and testbench
====================================

# rtc_bus_responder

Bus-side model and responder for the external RTC: it answers the multiplexed address/data strobes issued by the RTC bus master (cs_n, rd_n, wr_n, a_d, ad) and keeps time in BCD with a 1 Hz tick. It provides a BCD countdown timer and an active-low interrupt that is cleared over the bus. It is used both as the on-board substitute for the RTC chip and as the responder in master-controller benches.

## Interface
- TICK_DIV, 100000000: clk cycles per one-second tick. Benches use a small value, e.g. 16.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- cs_n  in  1  chip select, active-low, asynchronous to clk.
- rd_n  in  1  read strobe, active-low.
- wr_n  in  1  write strobe, active-low.
- a_d  in  1  phase select: 1 = address phase, 0 = data phase.
- ad_in  in  8  bus value from the master.
- ad_out  out  8  read data.
- ad_oe  out  1  responder drives the bus. The tristate buffer sits at the top level.
- irq_n  out  1  interrupt, active-low.

## Operation
- Synchronization: cs_n, rd_n, wr_n and a_d each pass through a 2-flop synchronizer. ad_in is sampled only on a wr_n rising edge, after synchronization, and must be stable from wr_n falling to rising.
- Write cycle: cs_n=0 and wr_n=0, then a rising edge of wr_n.
  - a_d=1: latch ad_in into the address register (addr).
  - a_d=0: write ad_in into the register at addr.
- Read cycle: ad_oe=1 while synchronized cs_n=0, rd_n=0 and a_d=0. ad_out is a registered copy of reg[addr], updated every cycle.
- ad_oe=0 and ad_out=0x00 otherwise.
- Register map (BCD):
  - 0x21 seconds 00-59
  - 0x22 minutes 00-59
  - 0x23 hours 00-23
  - 0x24 day 01-31
  - 0x25 month 01-12
  - 0x26 year 00-99
  - 0x41 timer seconds 00-59
  - 0x42 timer minutes 00-59
  - 0x43 timer hours 00-23
  - 0x00 control:
    - bit0 TEN, timer enable, R/W.
    - bit1 IRQF, irq flag. Read-only; writing 1 clears it.
    - Other bits read 0.
  - Unmapped addresses read 0x00; writes to them are ignored.
- Tick counter: 0..TICK_DIV-1, wraps, and emits a one-cycle tick at wrap.
- Timekeeping on each tick is a chained BCD increment:
  - Increment rule: if value >= max, wrap to min and carry. Otherwise add 1; units digit 9 goes to 0 with tens+1.
  - Out-of-range values written by the master therefore wrap at the next increment.
  - Day max depends on month: 31/28/31/30/31/30/31/31/30/31/30/31.
  - February max is 29 in leap years: year BCD tens even with units in {0,4,8}, or tens odd with units in {2,6}.
  - Month carry goes into year. Year 99 wraps to 00 with no further carry.
- Countdown timer, on each tick when TEN=1:
  - If timer != 00:00:00: BCD decrement with borrow. Seconds 00 go to 59 and borrow from minutes; minutes 00 go to 59 and borrow from hours.
  - When the timer reaches, or already is, 00:00:00 on a tick with TEN=1: set IRQF and clear TEN.
- irq_n = ~IRQF, registered.
- Write/tick collision: a bus write commit has priority. A tick that coincides with a write commit is held pending one cycle and then applied to the updated registers. No tick is ever lost.
- Writing IRQF=1 in the same cycle the timer sets it: the set wins and IRQF stays 1.

## Timing
- Reset values:
  - seconds 00, minutes 00, hours 00, day 01, month 01, year 00
  - timer 00:00:00, control 0x00, addr 0x00
  - tick counter 0, synchronizer flops 1 (inactive)
  - ad_out 0x00, ad_oe 0, irq_n 1
- rst mid-transfer: aborts the transfer immediately and returns everything to the reset values.
- Write latency: the register updates 3 clk after the wr_n rising edge at the pin (2 sync stages + edge detect).
- Read latency:
  - ad_oe rises 2 clk after the last of cs_n/rd_n/a_d reaches its active level, and falls 2 clk after any of them deasserts.
  - ad_out is valid 3 clk after rd_n falls.
  - The master holds rd_n low at least 4 clk and samples after the third.
- Strobe timing required from the master:
  - wr_n low at least 3 clk.
  - At least 3 clk between strobes.
  - a_d and cs_n stable for the whole strobe.
- irq_n falls 1 clk after the tick that sets IRQF. It rises 1 clk after the IRQF-clear write commits.
- Tick-driven register updates are visible 1 clk after the tick, or 2 clk after it when the tick was deferred by a collision.

## Test plan
- Reset, then read 0x21 and 0x24 → 0x00 and 0x01. Reads of 0x00 and 0x7F → 0x00. irq_n=1 and ad_oe=0 during reset.
- Write seconds=0x59, minutes=0x59, hours=0x23, day=0x31, month=0x12, year=0x99, then one tick → 00:00:00, day 0x01, month 0x01, year 0x00.
- Write day 0x28, month 0x02, year 0x24, then tick × 86400 (TICK_DIV=2) → day 0x29. Repeat with year 0x23 → day 0x01, month 0x03.
- Timer = 00:01:01, control=0x01 → after 61 ticks timer reads 00:00:00, irq_n=0, control reads 0x02. Write control=0x02 → irq_n=1 within 4 clk of the wr_n rising edge.
- Write seconds=0x30 with its commit in the same cycle as a tick → seconds reads 0x31, not 0x30. Tick count is preserved over 10 subsequent ticks.
- Assert rst mid-write (wr_n low, a_d=0, addr=0x21, ad_in=0x45) → seconds stays 0x00 and addr returns to 0x00.

Source files
------------

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder
//   Responder for the multiplexed RTC bus. It keeps BCD calendar time that
//   advances on a 1 Hz tick derived from clk, and runs a BCD countdown timer
//   whose expiry raises an active-low interrupt that is cleared over the bus.
//
// Ports
//   clk     system clock
//   rst     asynchronous, active-high reset
//   cs_n    chip select, active-low (asynchronous to clk)
//   rd_n    read strobe, active-low
//   wr_n    write strobe, active-low
//   a_d     phase select: 1 = address phase, 0 = data phase
//   ad_in   bus value from the master (address or write data)
//   ad_out  read data (0x00 whenever ad_oe is low)
//   ad_oe   responder drives the bus; the tristate buffer lives above this block
//   irq_n   interrupt, active-low, mirrors the IRQF control bit
//
// Register map (BCD): 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month,
// 0x26 year, 0x41/0x42/0x43 timer sec/min/hour, 0x00 control {IRQF, TEN}.
module rtc_bus_responder #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a_d,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       irq_n
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    localparam logic [7:0] A_CTRL  = 8'h00;
    localparam logic [7:0] A_SEC   = 8'h21;
    localparam logic [7:0] A_MIN   = 8'h22;
    localparam logic [7:0] A_HOUR  = 8'h23;
    localparam logic [7:0] A_DAY   = 8'h24;
    localparam logic [7:0] A_MONTH = 8'h25;
    localparam logic [7:0] A_YEAR  = 8'h26;
    localparam logic [7:0] A_TSEC  = 8'h41;
    localparam logic [7:0] A_TMIN  = 8'h42;
    localparam logic [7:0] A_THOUR = 8'h43;

    // BCD increment value: wraps to vmin at or above vmax, otherwise +1 with
    // units 9 rolling into the tens digit. Carry is (v >= vmax), computed
    // by the caller.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] vmin,
                                           input logic [7:0] vmax);
        if (v >= vmax)
            return vmin;
        if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD decrement value: 00 wraps to vmax (borrow is v == 0, by the caller).
    function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                           input logic [7:0] vmax);
        if (v == 8'h00)
            return vmax;
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Leap year on a two-digit BCD year: tens even with units 0/4/8, or
    // tens odd with units 2/6. Tens parity is bit 4.
    function automatic logic is_leap(input logic [7:0] yr);
        if (!yr[4])
            return (yr[3:0] == 4'd0) || (yr[3:0] == 4'd4) || (yr[3:0] == 4'd8);
        return (yr[3:0] == 4'd2) || (yr[3:0] == 4'd6);
    endfunction

    function automatic logic [7:0] month_days(input logic [7:0] mo,
                                              input logic [7:0] yr);
        case (mo)
            8'h02:                      return is_leap(yr) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    // Synchronizers (idle level is 1 for every strobe and for a_d)
    logic cs_s1, cs_s2;
    logic rd_s1, rd_s2;
    logic wr_s1, wr_s2, wr_d;
    logic ad_s1, ad_s2;

    // Register file and control
    logic [7:0]    addr;
    logic [7:0]    sec, min, hour, day, month, year;
    logic [7:0]    tsec, tmin, thour;
    logic          ten, irqf;
    logic [CW-1:0] tick_cnt;
    logic          tick_pend;
    logic [7:0]    ad_out_q;

    logic       tick, commit, addr_wr, data_wr, tick_apply;
    logic [7:0] nx_sec, nx_min, nx_hour, nx_day, nx_month, nx_year;
    logic [7:0] nx_tsec, nx_tmin, nx_thour;
    logic       c_sec, c_min, c_hour, c_day, c_month;
    logic       b_tsec, b_tmin;
    logic       tmr_zero, tmr_dec_zero;
    logic [7:0] rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_s1 <= 1'b1;
            cs_s2 <= 1'b1;
            rd_s1 <= 1'b1;
            rd_s2 <= 1'b1;
            wr_s1 <= 1'b1;
            wr_s2 <= 1'b1;
            wr_d  <= 1'b1;
            ad_s1 <= 1'b1;
            ad_s2 <= 1'b1;
        end else begin
            cs_s1 <= cs_n;
            cs_s2 <= cs_s1;
            rd_s1 <= rd_n;
            rd_s2 <= rd_s1;
            wr_s1 <= wr_n;
            wr_s2 <= wr_s1;
            wr_d  <= wr_s2;
            ad_s1 <= a_d;
            ad_s2 <= ad_s1;
        end
    end

    // A write commits on the synchronized wr_n rising edge while selected.
    assign commit  = wr_s2 & ~wr_d & ~cs_s2;
    assign addr_wr = commit & ad_s2;
    assign data_wr = commit & ~ad_s2;

    assign tick = (tick_cnt == TICK_LAST);

    // A tick that lands on a commit cycle waits one cycle in tick_pend, so
    // the write always sees the register file first and no tick is dropped.
    assign tick_apply = (tick | tick_pend) & ~commit;

    // Calendar chain
    always_comb begin
        c_sec    = (sec >= 8'h59);
        nx_sec   = bcd_inc(sec, 8'h00, 8'h59);
        c_min    = 1'b0;
        nx_min   = min;
        c_hour   = 1'b0;
        nx_hour  = hour;
        c_day    = 1'b0;
        nx_day   = day;
        c_month  = 1'b0;
        nx_month = month;
        nx_year  = year;
        if (c_sec) begin
            c_min  = (min >= 8'h59);
            nx_min = bcd_inc(min, 8'h00, 8'h59);
        end
        if (c_min) begin
            c_hour  = (hour >= 8'h23);
            nx_hour = bcd_inc(hour, 8'h00, 8'h23);
        end
        if (c_hour) begin
            c_day  = (day >= month_days(month, year));
            nx_day = bcd_inc(day, 8'h01, month_days(month, year));
        end
        if (c_day) begin
            c_month  = (month >= 8'h12);
            nx_month = bcd_inc(month, 8'h01, 8'h12);
        end
        if (c_month)
            nx_year = bcd_inc(year, 8'h00, 8'h99);
    end

    // Countdown chain
    always_comb begin
        tmr_zero = (tsec == 8'h00) && (tmin == 8'h00) && (thour == 8'h00);
        b_tsec   = (tsec == 8'h00);
        nx_tsec  = bcd_dec(tsec, 8'h59);
        b_tmin   = 1'b0;
        nx_tmin  = tmin;
        nx_thour = thour;
        if (b_tsec) begin
            b_tmin  = (tmin == 8'h00);
            nx_tmin = bcd_dec(tmin, 8'h59);
        end
        if (b_tmin)
            nx_thour = bcd_dec(thour, 8'h23);
        tmr_dec_zero = (nx_tsec == 8'h00) && (nx_tmin == 8'h00) &&
                       (nx_thour == 8'h00);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            tick_pend <= 1'b0;
            addr      <= 8'h00;
            sec       <= 8'h00;
            min       <= 8'h00;
            hour      <= 8'h00;
            day       <= 8'h01;
            month     <= 8'h01;
            year      <= 8'h00;
            tsec      <= 8'h00;
            tmin      <= 8'h00;
            thour     <= 8'h00;
            ten       <= 1'b0;
            irqf      <= 1'b0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + CW'(1);
            tick_pend <= (tick | tick_pend) & commit;

            // Commits and tick updates never share a cycle, so a timer
            // expiry can never be masked by an IRQF-clear write.
            if (addr_wr) begin
                addr <= ad_in;
            end else if (data_wr) begin
                case (addr)
                    A_CTRL: begin
                        ten <= ad_in[0];
                        if (ad_in[1])
                            irqf <= 1'b0;
                    end
                    A_SEC:   sec   <= ad_in;
                    A_MIN:   min   <= ad_in;
                    A_HOUR:  hour  <= ad_in;
                    A_DAY:   day   <= ad_in;
                    A_MONTH: month <= ad_in;
                    A_YEAR:  year  <= ad_in;
                    A_TSEC:  tsec  <= ad_in;
                    A_TMIN:  tmin  <= ad_in;
                    A_THOUR: thour <= ad_in;
                    default: ;
                endcase
            end else if (tick_apply) begin
                sec   <= nx_sec;
                min   <= nx_min;
                hour  <= nx_hour;
                day   <= nx_day;
                month <= nx_month;
                year  <= nx_year;
                if (ten) begin
                    if (tmr_zero) begin
                        irqf <= 1'b1;
                        ten  <= 1'b0;
                    end else begin
                        tsec  <= nx_tsec;
                        tmin  <= nx_tmin;
                        thour <= nx_thour;
                        if (tmr_dec_zero) begin
                            irqf <= 1'b1;
                            ten  <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            A_CTRL:  rd_data = {6'd0, irqf, ten};
            A_SEC:   rd_data = sec;
            A_MIN:   rd_data = min;
            A_HOUR:  rd_data = hour;
            A_DAY:   rd_data = day;
            A_MONTH: rd_data = month;
            A_YEAR:  rd_data = year;
            A_TSEC:  rd_data = tsec;
            A_TMIN:  rd_data = tmin;
            A_THOUR: rd_data = thour;
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ad_out_q <= 8'h00;
        else
            ad_out_q <= rd_data;
    end

    assign ad_oe  = ~cs_s2 & ~rd_s2 & ~ad_s2;
    assign ad_out = ad_oe ? ad_out_q : 8'h00;
    assign irq_n  = ~irqf;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Testbench for rtc_bus_responder: table-driven register read/write vectors
// plus hand-written sequences for calendar rollover, leap years, countdown
// expiry, write/tick collision and reset during a write.
module tb_rtc_bus_responder;

    localparam int TD = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       a_d = 1'b1;
    logic [7:0] ad_in = 8'h00;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       irq_n;

    int tests = 0;
    int fails = 0;
    int ph;

    rtc_bus_responder #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .a_d(a_d), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .irq_n(irq_n)
    );

    always #5 clk = ~clk;

    // Position within the one-second period; the tick fires in the cycle
    // where ph == TD-1 and its effect is visible once ph returns to 0.
    always @(posedge clk or posedge rst)
        if (rst) ph <= 0;
        else     ph <= (ph == TD - 1) ? 0 : ph + 1;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } rw_vec_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait until n more ticks have been applied.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do cyc(1); while (ph != 0);
        end
    endtask

    task automatic wstrobe(input logic phase, input logic [7:0] v);
        a_d = phase; ad_in = v; cs_n = 1'b0;
        cyc(1);
        wr_n = 1'b0;
        cyc(4);
        wr_n = 1'b1;
        cyc(4);
        cs_n = 1'b1; a_d = 1'b1;
        cyc(3);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] v);
        wstrobe(1'b1, a);
        wstrobe(1'b0, v);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d,
                            output logic oe);
        wstrobe(1'b1, a);
        a_d = 1'b0; cs_n = 1'b0; rd_n = 1'b0;
        cyc(4);
        d = ad_out; oe = ad_oe;
        rd_n = 1'b1; cs_n = 1'b1; a_d = 1'b1;
        cyc(3);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a,
                          input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        bus_read(a, d, oe);
        chk({name, "_oe"}, {7'd0, oe}, 8'h01);
        chk(name, d, exp);
    endtask

    task automatic set_time(input logic [7:0] s, input logic [7:0] m,
                            input logic [7:0] h, input logic [7:0] d,
                            input logic [7:0] mo, input logic [7:0] y);
        wait_ticks(1);
        bus_write(8'h26, y);
        bus_write(8'h25, mo);
        bus_write(8'h24, d);
        bus_write(8'h23, h);
        bus_write(8'h22, m);
        bus_write(8'h21, s);
    endtask

    rw_vec_t rw_tab[6];
    rd_vec_t roll_tab[6];

    initial begin
        rw_tab[0] = '{8'h22, 8'h37, 8'h37};
        rw_tab[1] = '{8'h23, 8'h15, 8'h15};
        rw_tab[2] = '{8'h41, 8'h12, 8'h12};
        rw_tab[3] = '{8'h7F, 8'h55, 8'h00};  // unmapped
        rw_tab[4] = '{8'h00, 8'hFE, 8'h00};  // IRQF cannot be set by a write
        rw_tab[5] = '{8'h43, 8'h07, 8'h07};

        roll_tab[0] = '{8'h21, 8'h00};
        roll_tab[1] = '{8'h22, 8'h00};
        roll_tab[2] = '{8'h23, 8'h00};
        roll_tab[3] = '{8'h24, 8'h01};
        roll_tab[4] = '{8'h25, 8'h01};
        roll_tab[5] = '{8'h26, 8'h00};

        // Reset state
        cyc(3);
        chk("rst_irq_n", {7'd0, irq_n}, 8'h01);
        chk("rst_ad_oe", {7'd0, ad_oe}, 8'h00);
        chk("rst_ad_out", ad_out, 8'h00);
        rst = 1'b0;
        cyc(2);
        rd_chk("rst_sec", 8'h21, 8'h00);
        rd_chk("rst_day", 8'h24, 8'h01);
        rd_chk("rst_ctrl", 8'h00, 8'h00);
        rd_chk("rst_unmapped", 8'h7F, 8'h00);
        chk("idle_ad_oe", {7'd0, ad_oe}, 8'h00);
        chk("idle_ad_out", ad_out, 8'h00);

        // Register write/read-back vectors
        for (int i = 0; i < 6; i++) begin
            wait_ticks(1);
            bus_write(rw_tab[i].addr, rw_tab[i].wdata);
            rd_chk($sformatf("reg_rw[%0d]", i), rw_tab[i].addr, rw_tab[i].exp);
        end

        // Full calendar rollover on one tick
        set_time(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99);
        wait_ticks(1);
        for (int i = 0; i < 6; i++)
            rd_chk($sformatf("rollover[%0d]", i), roll_tab[i].addr, roll_tab[i].exp);

        // Leap-year February
        set_time(8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 8'h24);
        wait_ticks(1);
        rd_chk("leap_day", 8'h24, 8'h29);
        rd_chk("leap_month", 8'h25, 8'h02);

        // Non-leap February
        set_time(8'h59, 8'h59, 8'h23, 8'h28, 8'h02, 8'h23);
        wait_ticks(1);
        rd_chk("nonleap_day", 8'h24, 8'h01);
        rd_chk("nonleap_month", 8'h25, 8'h03);

        // 30-day month
        set_time(8'h59, 8'h59, 8'h23, 8'h30, 8'h04, 8'h23);
        wait_ticks(1);
        rd_chk("apr_day", 8'h24, 8'h01);
        rd_chk("apr_month", 8'h25, 8'h05);

        // Countdown 00:01:01 -> expiry on the 61st tick
        wait_ticks(1);
        bus_write(8'h41, 8'h01);
        bus_write(8'h42, 8'h01);
        bus_write(8'h43, 8'h00);
        wait_ticks(1);
        bus_write(8'h00, 8'h01);
        wait_ticks(60);
        chk("tmr_60_irq_n", {7'd0, irq_n}, 8'h01);
        rd_chk("tmr_60_sec", 8'h41, 8'h01);
        rd_chk("tmr_60_min", 8'h42, 8'h00);
        wait_ticks(1);
        chk("tmr_61_irq_n", {7'd0, irq_n}, 8'h00);
        rd_chk("tmr_61_sec", 8'h41, 8'h00);
        rd_chk("tmr_61_min", 8'h42, 8'h00);
        rd_chk("tmr_61_ctrl", 8'h00, 8'h02);
        wait_ticks(1);
        chk("tmr_idle_irq_n", {7'd0, irq_n}, 8'h00);
        bus_write(8'h00, 8'h02);
        chk("irq_clear_irq_n", {7'd0, irq_n}, 8'h01);
        rd_chk("irq_clear_ctrl", 8'h00, 8'h00);

        // Write commit coinciding with the tick: wr_n rises so that its
        // synchronized edge lands in the ph == TD-1 cycle.
        wait_ticks(1);
        wstrobe(1'b1, 8'h21);
        a_d = 1'b0; ad_in = 8'h30; cs_n = 1'b0;
        while (ph != TD - 6) cyc(1);
        wr_n = 1'b0;
        while (ph != TD - 3) cyc(1);
        wr_n = 1'b1;
        cyc(4);
        cs_n = 1'b1; a_d = 1'b1;
        cyc(3);
        rd_chk("collide_sec", 8'h21, 8'h31);
        wait_ticks(10);
        rd_chk("collide_10_ticks", 8'h21, 8'h41);

        // Reset in the middle of a seconds write
        wait_ticks(1);
        wstrobe(1'b1, 8'h21);
        a_d = 1'b0; ad_in = 8'h45; cs_n = 1'b0; wr_n = 1'b0;
        cyc(2);
        rst = 1'b1;
        #1;
        chk("midrst_irq_n", {7'd0, irq_n}, 8'h01);
        chk("midrst_ad_oe", {7'd0, ad_oe}, 8'h00);
        cyc(2);
        wr_n = 1'b1; cs_n = 1'b1; a_d = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        // A bare data phase lands at the (reset) address 0x00: sets TEN.
        wstrobe(1'b0, 8'h01);
        rd_chk("midrst_addr", 8'h00, 8'h01);
        rd_chk("midrst_sec", 8'h21, 8'h00);
        bus_write(8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
